// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-port block RAM arbiter.
package bram_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins; on a tie the port that was not granted last wins.
module rr_arb2
    import bram_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    assign grant[0] = valid[0] & (~valid[1] | (last_grant == PORT_B));
    assign grant[1] = valid[1] & (~valid[0] | (last_grant == PORT_A));

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port, read-first, 1-cycle-latency block RAM between requesters A and B.
// Zero-fills (or INIT_VALUE-fills) the RAM after reset, then grants at most one access per cycle.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int                       ADDR_WIDTH = 4,
    parameter int                       RAM_WIDTH  = 8,
    parameter int                       RAM_DEPTH  = 16,
    parameter int                       INIT_EN    = 1,
    parameter logic [RAM_WIDTH-1:0]     INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    // Handshake: a request is taken on a rising edge where *_valid and *_ready are both high;
    // the requester holds valid and payload stable until then. Read data returns one cycle later.
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [RAM_WIDTH-1:0]  a_wdata,
    output logic                  a_rvalid,
    output logic [RAM_WIDTH-1:0]  a_rdata,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [RAM_WIDTH-1:0]  b_wdata,
    output logic                  b_rvalid,
    output logic [RAM_WIDTH-1:0]  b_rdata,
    output logic                  ram_wen,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [RAM_WIDTH-1:0]  ram_wdata,
    input  logic [RAM_WIDTH-1:0]  ram_rdata,
    output logic                  init_done,
    output state_t                dbg_state
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic                  r_last_grant;
    logic [1:0]            r_rd_pend;
    logic                  r_init_done;

    logic                  w_run;
    logic [1:0]            w_valid;
    logic [1:0]            w_grant;
    logic [1:0]            w_we;

    assign w_run   = (r_state == ST_RUN);
    assign w_valid = {b_valid, a_valid} & {2{w_run}};
    assign w_we    = {b_we, a_we};

    rr_arb2 u_rr_arb2 (
        .valid      (w_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    // While reset is held the init sweep must not write, so the write enable is gated by rst.
    always_comb begin
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (r_state == ST_INIT) begin
            ram_wen   = ~rst;
            ram_addr  = r_init_cnt;
            ram_wdata = INIT_VALUE;
        end else if (w_grant[0]) begin
            ram_wen   = a_we;
            ram_addr  = a_addr;
            ram_wdata = a_wdata;
        end else if (w_grant[1]) begin
            ram_wen   = b_we;
            ram_addr  = b_addr;
            ram_wdata = b_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            r_init_cnt   <= '0;
            r_last_grant <= PORT_B;
            r_rd_pend    <= 2'b00;
            r_init_done  <= 1'b0;
        end else begin
            r_rd_pend <= w_grant & ~w_we;
            if (w_grant[0]) begin
                r_last_grant <= PORT_A;
            end else if (w_grant[1]) begin
                r_last_grant <= PORT_B;
            end
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
                if (r_init_cnt == LAST_ADDR) begin
                    r_state     <= ST_RUN;
                    r_init_cnt  <= '0;
                    r_init_done <= 1'b1;
                end
            end else begin
                r_init_done <= 1'b1;
            end
        end
    end

    assign a_ready   = w_grant[0];
    assign b_ready   = w_grant[1];
    assign a_rvalid  = r_rd_pend[0];
    assign b_rvalid  = r_rd_pend[1];
    assign a_rdata   = r_rd_pend[0] ? ram_rdata : '0;
    assign b_rdata   = r_rd_pend[1] ? ram_rdata : '0;
    assign init_done = r_init_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench: arbiter with init sweep plus a read-first RAM model, and a second instance with init disabled.
module tb_bram_arbiter;
    import bram_arb_pkg::*;

    logic       clk;
    logic       rst;

    logic       a_valid, a_ready, a_we, a_rvalid;
    logic [3:0] a_addr;
    logic [7:0] a_wdata, a_rdata;
    logic       b_valid, b_ready, b_we, b_rvalid;
    logic [3:0] b_addr;
    logic [7:0] b_wdata, b_rdata;
    logic       ram_wen;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata;
    logic       init_done;
    state_t     dbg_state;

    logic       a2_valid, a2_ready, a2_we, a2_rvalid;
    logic [3:0] a2_addr;
    logic [7:0] a2_wdata, a2_rdata;
    logic       b2_valid, b2_ready, b2_we, b2_rvalid;
    logic [3:0] b2_addr;
    logic [7:0] b2_wdata, b2_rdata;
    logic       ram2_wen;
    logic [3:0] ram2_addr;
    logic [7:0] ram2_wdata, ram2_rdata;
    logic       init2_done;
    state_t     dbg2_state;

    logic [7:0] mem [16];

    int checks;
    int failures;
    int cnt_a;
    int cnt_b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    bram_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .init_done(init_done), .dbg_state(dbg_state)
    );

    bram_arbiter #(.INIT_EN(0)) dut2 (
        .clk(clk), .rst(rst),
        .a_valid(a2_valid), .a_ready(a2_ready), .a_we(a2_we), .a_addr(a2_addr), .a_wdata(a2_wdata),
        .a_rvalid(a2_rvalid), .a_rdata(a2_rdata),
        .b_valid(b2_valid), .b_ready(b2_ready), .b_we(b2_we), .b_addr(b2_addr), .b_wdata(b2_wdata),
        .b_rvalid(b2_rvalid), .b_rdata(b2_rdata),
        .ram_wen(ram2_wen), .ram_addr(ram2_addr), .ram_wdata(ram2_wdata), .ram_rdata(ram2_rdata),
        .init_done(init2_done), .dbg_state(dbg2_state)
    );

    // Read-first RAM with one-cycle registered read; pre-filled with 0xFF so the init sweep is visible.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] <= 8'hFF;
    end

    always @(posedge clk) begin
        if (ram_wen) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0; failures = 0; cnt_a = 0; cnt_b = 0;
        rst = 1'b1;
        a_valid = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_valid = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        a2_valid = 0; a2_we = 0; a2_addr = 0; a2_wdata = 0;
        b2_valid = 0; b2_we = 0; b2_addr = 0; b2_wdata = 0;
        ram2_rdata = 8'h3C;

        // Reset state
        repeat (2) tick();
        settle();
        check("rst_init_done", init_done, 0);
        check("rst_ram_wen", ram_wen, 0);
        check("rst_a_rvalid", a_rvalid, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_init2_done", init2_done, 0);

        // Init sweep: 16 writes of 0 to addresses 0..15; A request held off
        a_valid = 1; a_we = 0; a_addr = 4'd5;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            settle();
            check("init_wen", ram_wen, 1);
            check("init_addr", ram_addr, i);
            check("init_wdata", ram_wdata, 0);
            check("init_a_ready", a_ready, 0);
            check("init_done_low", init_done, 0);
            if (i == 0) check("init_state", dbg_state, ST_INIT);
            tick();
        end
        settle();
        check("run_init_done", init_done, 1);
        check("run_first_a_ready", a_ready, 1);
        check("run_first_ram_addr", ram_addr, 5);
        check("run_first_ram_wen", ram_wen, 0);
        tick();
        a_valid = 0;
        b_valid = 1; b_we = 0; b_addr = 4'd15;
        settle();
        check("zero_a_rvalid", a_rvalid, 1);
        check("zero_a_rdata", a_rdata, 8'h00);
        check("zero_b_ready", b_ready, 1);
        tick();
        b_valid = 0;
        settle();
        check("zero_b_rvalid", b_rvalid, 1);
        check("zero_b_rdata", b_rdata, 8'h00);

        // A writes 0x5A@3, then reads @3
        a_valid = 1; a_we = 1; a_addr = 4'd3; a_wdata = 8'h5A;
        settle();
        check("wr_a_ready", a_ready, 1);
        check("wr_ram_wen", ram_wen, 1);
        check("wr_ram_addr", ram_addr, 3);
        check("wr_ram_wdata", ram_wdata, 8'h5A);
        tick();
        a_we = 0;
        settle();
        check("rd_a_ready", a_ready, 1);
        check("rd_ram_wen", ram_wen, 0);
        check("rd_no_early_rvalid", a_rvalid, 0);
        tick();
        a_valid = 0;
        settle();
        check("rd_a_rvalid", a_rvalid, 1);
        check("rd_a_rdata", a_rdata, 8'h5A);
        check("rd_b_rvalid", b_rvalid, 0);
        tick();
        settle();
        check("rd_a_rvalid_drop", a_rvalid, 0);
        check("rd_a_rdata_zero", a_rdata, 8'h00);

        // B writes 0xC3@7 then reads @7 back-to-back, A idle
        b_valid = 1; b_we = 1; b_addr = 4'd7; b_wdata = 8'hC3;
        settle();
        check("b_wr_ready", b_ready, 1);
        check("b_wr_a_ready", a_ready, 0);
        check("b_wr_ram_addr", ram_addr, 7);
        check("b_wr_ram_wen", ram_wen, 1);
        tick();
        b_we = 0;
        settle();
        check("b_rd_ready", b_ready, 1);
        tick();
        b_valid = 0;
        settle();
        check("b_rd_rvalid", b_rvalid, 1);
        check("b_rd_rdata", b_rdata, 8'hC3);
        check("b_rd_a_rvalid", a_rvalid, 0);
        tick();

        // Contention: both read continuously, grants alternate starting with A
        a_valid = 1; a_we = 0; a_addr = 4'd3;
        b_valid = 1; b_we = 0; b_addr = 4'd7;
        for (int k = 0; k < 8; k++) begin
            settle();
            check("alt_a_ready", a_ready, (k % 2 == 0) ? 1 : 0);
            check("alt_b_ready", b_ready, (k % 2 == 1) ? 1 : 0);
            if (a_rvalid) begin cnt_a++; check("alt_a_rdata", a_rdata, 8'h5A); end
            if (b_rvalid) begin cnt_b++; check("alt_b_rdata", b_rdata, 8'hC3); end
            tick();
        end
        a_valid = 0; b_valid = 0;
        settle();
        if (a_rvalid) cnt_a++;
        if (b_rvalid) begin cnt_b++; check("alt_b_rdata_last", b_rdata, 8'hC3); end
        check("alt_cnt_a", cnt_a, 4);
        check("alt_cnt_b", cnt_b, 4);
        tick();

        // Reset lands in the cycle a read would respond
        a_valid = 1; a_we = 0; a_addr = 4'd3;
        settle();
        check("rst5_a_ready", a_ready, 1);
        tick();
        rst = 1'b1;
        a_valid = 0;
        settle();
        check("rst5_a_rvalid", a_rvalid, 0);
        check("rst5_a_rdata", a_rdata, 8'h00);
        check("rst5_init_done", init_done, 0);
        tick();
        a2_valid = 1; a2_we = 0; a2_addr = 4'd1;
        rst = 1'b0;
        settle();
        check("rst5_init_addr0", ram_addr, 0);
        check("rst5_init_wen", ram_wen, 1);
        check("noinit_a2_ready", a2_ready, 1);
        check("noinit_done_pre", init2_done, 0);
        tick();
        a2_valid = 0;
        settle();
        check("noinit_done", init2_done, 1);
        check("noinit_a2_rvalid", a2_rvalid, 1);
        check("noinit_a2_rdata", a2_rdata, 8'h3C);
        check("rst5_init_addr1", ram_addr, 1);
        check("rst5_a_rvalid_quiet", a_rvalid, 0);
        repeat (14) tick();
        settle();
        check("rst5_init_last_addr", ram_addr, 15);
        check("rst5_done_not_yet", init_done, 0);
        tick();
        settle();
        check("rst5_init_done", init_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
